mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one pipelined 16-bit memory port between an I-cache
//               (line fills only) and a D-cache (line fills and single-word
//               write-through). Fixed priority, D over I, decided only in IDLE.
//               A line fill issues WORDS consecutive reads of the aligned line
//               while accepting returning data in the same cycles. The
//               returning words are streamed to the owning cache with their
//               word offset.
// Ports       : clk, rst                         clock / async active-high reset
//               i_req, i_addr                    I-cache fill request
//               d_req, d_wr, d_addr, d_wdata     D-cache fill/write request
//               mem_en, mem_wr, mem_addr,
//               mem_wdata, mem_rdata, mem_valid  memory port
//               fill_data, fill_word,
//               i_fill_we, d_fill_we             fill stream to the caches
//               i_done, d_done                   one-cycle completion pulses
//               busy                             transaction in progress
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int WORDS = 8,
    parameter int OW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [15:0]   i_addr,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [15:0]   d_addr,
    input  logic [15:0]   d_wdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          mem_valid,
    output logic [15:0]   fill_data,
    output logic [OW-1:0] fill_word,
    output logic          i_fill_we,
    output logic          d_fill_we,
    output logic          i_done,
    output logic          d_done,
    output logic          busy
);

    // Line base is the byte address above the word offset and byte bit.
    localparam int BW = 15 - OW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic          c_OWNER_I = 1'b0;
    localparam logic          c_OWNER_D = 1'b1;
    localparam logic [OW-1:0] c_LAST    = OW'(WORDS - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic          r_owner;
    logic [BW-1:0] r_base;
    // One extra bit: the MSB sets once all WORDS reads have been issued.
    logic [OW:0]   r_issue_cnt;
    logic [OW-1:0] r_recv_cnt;
    logic [15:0]   r_waddr;
    logic [15:0]   r_wdata;
    logic          w_issuing;
    logic          w_accept;

    // The byte and word-offset bits of a fill address are never needed.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, i_addr[OW:0]};

    assign w_issuing = (r_state == S_FILL) && !r_issue_cnt[OW];
    assign w_accept  = (r_state == S_FILL) && mem_valid;

    assign fill_data = mem_rdata;
    assign fill_word = r_recv_cnt;
    assign busy      = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;
        i_fill_we    = 1'b0;
        d_fill_we    = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_req) begin
                    w_next_state = d_wr ? S_WRITE : S_FILL;
                end else if (i_req) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                if (w_issuing) begin
                    mem_en   = 1'b1;
                    mem_addr = {r_base, r_issue_cnt[OW-1:0], 1'b0};
                end
                if (mem_valid) begin
                    if (r_owner == c_OWNER_D) begin
                        d_fill_we = 1'b1;
                    end else begin
                        i_fill_we = 1'b1;
                    end
                    if (r_recv_cnt == c_LAST) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                mem_en       = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = r_waddr;
                mem_wdata    = r_wdata;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                // Requesters drop req on this edge, so IDLE is re-entered
                // without looking at the request lines here.
                if (r_owner == c_OWNER_D) begin
                    d_done = 1'b1;
                end else begin
                    i_done = 1'b1;
                end
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant capture and fill counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= c_OWNER_I;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_waddr     <= 16'h0000;
            r_wdata     <= 16'h0000;
        end else begin
            if (r_state == S_IDLE) begin
                // Counters are held at zero while idle so every fill starts
                // at word 0 regardless of how the previous one ended.
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
                if (d_req) begin
                    r_owner <= c_OWNER_D;
                    r_base  <= d_addr[15:OW+1];
                    if (d_wr) begin
                        r_waddr <= d_addr;
                        r_wdata <= d_wdata;
                    end
                end else if (i_req) begin
                    r_owner <= c_OWNER_I;
                    r_base  <= i_addr[15:OW+1];
                end
            end
            if (w_issuing) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            // Data returning outside FILL is stale and must not move the
            // receive counter.
            if (w_accept) begin
                r_recv_cnt <= r_recv_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
